// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the pipelined MIPS core.
package cpu_types_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned REG_W  = 5;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [REG_W-1:0]  regbits_t;

   typedef enum logic {IDLE, STALL} fhu_state_t;

endpackage

// File: rtl/forward_hazard_unit_if.sv
// Bundle of forward_hazard_unit signals, with the unit's view and the bench's mirrored view.
interface forward_hazard_unit_if
   import cpu_types_pkg::*;
#(
   parameter int unsigned NUM_SRC = 2,
   parameter int unsigned CNT_W   = 32
) (
   input logic CLK,
   input logic nRST
);
   logic                  advance;
   logic                  flush;
   logic                  id_valid;
   regbits_t              id_rsel1;
   regbits_t              id_rsel2;
   regbits_t              ex_rsel1;
   regbits_t              ex_rsel2;
   word_t                 ex_rdat1_in;
   word_t                 ex_rdat2_in;
   logic                  ex_load;
   regbits_t              ex_wsel;
   logic [NUM_SRC-1:0]    src_wen;
   logic [NUM_SRC*5-1:0]  src_wsel;
   logic [NUM_SRC*32-1:0] src_wdat;
   logic                  cnt_clr;
   word_t                 rdat1_out;
   word_t                 rdat2_out;
   logic [2:0]            fwd_sel1;
   logic [2:0]            fwd_sel2;
   logic                  stall_id;
   logic [CNT_W-1:0]      stall_cycles;

   modport fhu (
      input  CLK, nRST, advance, flush, id_valid, id_rsel1, id_rsel2, ex_rsel1, ex_rsel2,
             ex_rdat1_in, ex_rdat2_in, ex_load, ex_wsel, src_wen, src_wsel, src_wdat, cnt_clr,
      output rdat1_out, rdat2_out, fwd_sel1, fwd_sel2, stall_id, stall_cycles
   );

   modport tb (
      input  CLK, nRST, rdat1_out, rdat2_out, fwd_sel1, fwd_sel2, stall_id, stall_cycles,
      output advance, flush, id_valid, id_rsel1, id_rsel2, ex_rsel1, ex_rsel2,
             ex_rdat1_in, ex_rdat2_in, ex_load, ex_wsel, src_wen, src_wsel, src_wdat, cnt_clr
   );

endinterface

// File: rtl/fwd_mux.sv
// Single-operand priority selector: youngest matching write-back source wins, $0 never forwarded.
module fwd_mux
   import cpu_types_pkg::*;
#(
   parameter int unsigned NUM_SRC = 2
) (
   input  regbits_t              rsel,
   input  word_t                 rdat_in,
   input  logic [NUM_SRC-1:0]    src_wen,
   input  logic [NUM_SRC*5-1:0]  src_wsel,
   input  logic [NUM_SRC*32-1:0] src_wdat,
   output word_t                 rdat_out,
   output logic [2:0]            fwd_sel
);

   // Scan oldest to youngest so the lowest matching index is the last assignment.
   always_comb begin
      rdat_out = rdat_in;
      fwd_sel  = 3'd0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (src_wen[i] && (src_wsel[5*i +: 5] == rsel) && (rsel != '0)) begin
            rdat_out = src_wdat[32*i +: 32];
            fwd_sel  = 3'(i + 1);
         end
      end
   end

endmodule

// File: rtl/forward_hazard_unit.sv
// Operand forwarding across NUM_SRC write-back sources, load-use bubble FSM and stall counter.
module forward_hazard_unit
   import cpu_types_pkg::*;
#(
   parameter int unsigned NUM_SRC    = 2,
   parameter int unsigned LU_BUBBLES = 1,
   parameter int unsigned CNT_W      = 32
) (
   input  logic                  CLK,
   input  logic                  nRST,
   input  logic                  advance,
   input  logic                  flush,
   input  logic                  id_valid,
   input  regbits_t              id_rsel1,
   input  regbits_t              id_rsel2,
   input  regbits_t              ex_rsel1,
   input  regbits_t              ex_rsel2,
   input  word_t                 ex_rdat1_in,
   input  word_t                 ex_rdat2_in,
   input  logic                  ex_load,
   input  regbits_t              ex_wsel,
   input  logic [NUM_SRC-1:0]    src_wen,
   input  logic [NUM_SRC*5-1:0]  src_wsel,
   input  logic [NUM_SRC*32-1:0] src_wdat,
   input  logic                  cnt_clr,
   output word_t                 rdat1_out,
   output word_t                 rdat2_out,
   output logic [2:0]            fwd_sel1,
   output logic [2:0]            fwd_sel2,
   output logic                  stall_id,
   output logic [CNT_W-1:0]      stall_cycles
);

   localparam int unsigned CW = $clog2(LU_BUBBLES + 1);

   fhu_state_t       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0] stall_cnt_q;
   logic             hz;

   fwd_mux #(.NUM_SRC(NUM_SRC)) u_fwd1 (
      .rsel     (ex_rsel1),
      .rdat_in  (ex_rdat1_in),
      .src_wen  (src_wen),
      .src_wsel (src_wsel),
      .src_wdat (src_wdat),
      .rdat_out (rdat1_out),
      .fwd_sel  (fwd_sel1)
   );

   fwd_mux #(.NUM_SRC(NUM_SRC)) u_fwd2 (
      .rsel     (ex_rsel2),
      .rdat_in  (ex_rdat2_in),
      .src_wen  (src_wen),
      .src_wsel (src_wsel),
      .src_wdat (src_wdat),
      .rdat_out (rdat2_out),
      .fwd_sel  (fwd_sel2)
   );

   assign hz = id_valid && ex_load && (ex_wsel != '0) &&
               ((ex_wsel == id_rsel1) || (ex_wsel == id_rsel2));

   // The first bubble is always the combinational hz cycle; STALL covers the remaining ones.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      stall_id = 1'b0;
      if (flush) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               stall_id = hz;
               if (hz && advance && (LU_BUBBLES > 1)) begin
                  state_d = STALL;
                  cnt_d   = CW'(LU_BUBBLES - 1);
               end
            end
            STALL: begin
               stall_id = 1'b1;
               if (advance) begin
                  if (cnt_q == CW'(1)) begin
                     state_d = IDLE;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q - CW'(1);
                  end
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_cnt_q <= '0;
      end else if (cnt_clr) begin
         stall_cnt_q <= '0;
      end else if (stall_id && advance && (stall_cnt_q != '1)) begin
         stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
   end

   assign stall_cycles = stall_cnt_q;

endmodule
